flushable_queue: RTL and testbench
==================================

FLUSHABLE_QUEUE -- requirements
Module: flushable_queue

Interface
REQ-001 Data, gpreg: element type carried on enq/deq.
REQ-002 DEPTH, 4: number of storage entries; any integer >= 1, power of two not required.
REQ-003 FALLTHROUGH, 0: when 1, an empty queue presents enq data on deq in the same cycle.
REQ-004 PIPE, 0: when 1, a full queue accepts an enqueue in a cycle where deq fires.
REQ-005 AFULL_THRESH, DEPTH-1: occupancy at or above which almost_full is asserted; range 1..DEPTH.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 flush  in  1  synchronous discard of all contents.
REQ-009 enq  decoupled.in  Data  producer side (valid, ready, data); fire = valid && ready.
REQ-010 deq  decoupled.out  Data  consumer side (valid, ready, data); fire = valid && ready.
REQ-011 count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
REQ-012 almost_full  out  1  count >= AFULL_THRESH.

Function
REQ-013 All DEPTH entries SHALL be usable: full = (count == DEPTH), empty = (count == 0); no sacrificed slot.
REQ-014 head and tail pointers SHALL range 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly (no reliance on modulo-2^n overflow).
REQ-015 enq.ready SHALL be !full when PIPE=0, and !full || deq.ready when PIPE=1; forced 0 while flush=1.
REQ-016 deq.valid SHALL be !empty and deq.data = store[head] when FALLTHROUGH=0.
REQ-017 With FALLTHROUGH=1 and empty: deq.valid = enq.valid, deq.data = enq.data; otherwise as REQ-016.
REQ-018 deq.valid SHALL be forced 0 while flush=1.
REQ-019 enq fire (non-bypass): store[tail] <= enq.data, tail advances, count +1 next cycle.
REQ-020 deq fire: head advances, count -1 next cycle.
REQ-021 Simultaneous enq and deq fire with count > 0: both pointers advance, count unchanged, PIPE full case included.
REQ-022 FALLTHROUGH bypass (empty, enq and deq both fire): no storage write, pointers and count unchanged.
REQ-023 flush=1: next cycle head = tail = 0, count = 0; no fire occurs in the flush cycle; storage contents left unchanged.
REQ-024 count and almost_full SHALL be driven from registered state only, no combinational path from enq/deq/flush.
REQ-025 Enqueue latency (FALLTHROUGH=0): data written in cycle N appears on deq in cycle N+1 earliest.
REQ-026 count SHALL never exceed DEPTH nor underflow below 0 under any legal handshake sequence.
REQ-027 DEPTH=1: pointers fixed at 0, queue alternates full/empty; PIPE=1 permits back-to-back throughput of one per cycle.

Reset
REQ-028 rst=1 SHALL asynchronously set head = tail = 0, count = 0; hence deq.valid = 0 (FALLTHROUGH=0), enq.ready = 1, almost_full = 0 (AFULL_THRESH >= 1).
REQ-029 Storage array SHALL not be reset.
REQ-030 rst asserted mid-transfer SHALL discard all contents immediately; first enq after deassertion lands in entry 0.

Verification
REQ-031 DEPTH=3, AFULL_THRESH=2: enqueue 0xA,0xB,0xC with deq.ready=0 -> count 1,2,3; almost_full high from count=2; enq.ready=0 at count=3; dequeue order 0xA,0xB,0xC.
REQ-032 DEPTH=3 wrap: 5 enqueue/dequeue pairs of 1..5 with occupancy held at 2 -> tail wraps 2->0, output stream 1..5 in order, count stays 2.
REQ-033 PIPE=1, DEPTH=3 full, deq.ready=1 and enq.valid=1 with 0x7 -> enq.ready=1, count stays 3, 0x7 emerges after the 3 prior entries.
REQ-034 FALLTHROUGH=1, empty, enq 0x55 with deq.ready=1 -> deq.valid=1, deq.data=0x55 same cycle, count stays 0.
REQ-035 count=2 with flush=1 and enq.valid=1 -> enq.ready=0, deq.valid=0; next cycle count=0, deq.valid=0; subsequent enq 0x9 dequeued as 0x9.
REQ-036 rst pulse between clock edges while count=3 -> count=0, deq.valid=0 before next rising edge.

Source files
------------

// File: rtl/flushable_queue.sv
// Flushable FIFO queue. Optional fall-through bypass when empty and optional
// pipelined enqueue into a full queue. Count and almost_full come from registered state.
module flushable_queue #(
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int FALLTHROUGH  = 0,
  parameter int PIPE         = 0,
  parameter int AFULL_THRESH = (DEPTH > 1) ? DEPTH - 1 : 1,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_enq_valid,
  output logic              o_enq_ready,
  input  logic [DATA_W-1:0] i_enq_data,
  output logic              o_deq_valid,
  input  logic              i_deq_ready,
  output logic [DATA_W-1:0] o_deq_data,
  output logic [CW-1:0]     o_count,
  output logic              o_almost_full
);

  logic [DATA_W-1:0] r_store [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_enq_fire;
  logic w_deq_fire;
  logic w_push;
  logic w_pop;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_bypass = (FALLTHROUGH != 0) && w_empty;

  assign o_enq_ready = !i_flush && (!w_full || ((PIPE != 0) && i_deq_ready));
  assign o_deq_valid = !i_flush && (w_bypass ? i_enq_valid : !w_empty);
  assign o_deq_data  = w_bypass ? i_enq_data : r_store[r_head];

  assign w_enq_fire = i_enq_valid && o_enq_ready;
  assign w_deq_fire = o_deq_valid && i_deq_ready;

  // A bypassed element passes straight through and never touches storage.
  assign w_push = w_enq_fire && !(w_bypass && w_deq_fire);
  assign w_pop  = w_deq_fire && !w_bypass;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= ptr_inc(r_tail);
      if (w_pop)  r_head <= ptr_inc(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_store[r_tail] <= i_enq_data;
  end

  assign o_count       = r_count;
  assign o_almost_full = (r_count >= CW'(AFULL_THRESH));

endmodule

// File: tb/tb_flushable_queue.sv
// Scoreboard bench for flushable_queue: four configurations driven with directed
// vectors; a negedge monitor checks every dequeue against the expected-data queues.
module tb_flushable_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] flush = '0;
  logic [3:0] enq_valid = '0;
  logic [3:0] enq_ready;
  logic [3:0] deq_valid;
  logic [3:0] deq_ready = '0;
  logic [3:0] afull;
  logic [7:0] enq_data [4];
  logic [7:0] deq_data [4];
  logic [1:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] cnt2;
  logic [0:0] cnt3;

  logic [7:0] exp_q [4][$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // A: DEPTH=3 plain; B: DEPTH=3 PIPE; C: DEPTH=4 FALLTHROUGH; D: DEPTH=1 PIPE
  flushable_queue #(.DATA_W(8), .DEPTH(3), .FALLTHROUGH(0), .PIPE(0), .AFULL_THRESH(2)) u_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[0]),
    .i_enq_valid(enq_valid[0]), .o_enq_ready(enq_ready[0]), .i_enq_data(enq_data[0]),
    .o_deq_valid(deq_valid[0]), .i_deq_ready(deq_ready[0]), .o_deq_data(deq_data[0]),
    .o_count(cnt0), .o_almost_full(afull[0]));

  flushable_queue #(.DATA_W(8), .DEPTH(3), .FALLTHROUGH(0), .PIPE(1), .AFULL_THRESH(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[1]),
    .i_enq_valid(enq_valid[1]), .o_enq_ready(enq_ready[1]), .i_enq_data(enq_data[1]),
    .o_deq_valid(deq_valid[1]), .i_deq_ready(deq_ready[1]), .o_deq_data(deq_data[1]),
    .o_count(cnt1), .o_almost_full(afull[1]));

  flushable_queue #(.DATA_W(8), .DEPTH(4), .FALLTHROUGH(1), .PIPE(0), .AFULL_THRESH(3)) u_c (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[2]),
    .i_enq_valid(enq_valid[2]), .o_enq_ready(enq_ready[2]), .i_enq_data(enq_data[2]),
    .o_deq_valid(deq_valid[2]), .i_deq_ready(deq_ready[2]), .o_deq_data(deq_data[2]),
    .o_count(cnt2), .o_almost_full(afull[2]));

  flushable_queue #(.DATA_W(8), .DEPTH(1), .FALLTHROUGH(0), .PIPE(1), .AFULL_THRESH(1)) u_d (
    .i_clk(clk), .i_rst(rst), .i_flush(flush[3]),
    .i_enq_valid(enq_valid[3]), .o_enq_ready(enq_ready[3]), .i_enq_data(enq_data[3]),
    .o_deq_valid(deq_valid[3]), .i_deq_ready(deq_ready[3]), .o_deq_data(deq_data[3]),
    .o_count(cnt3), .o_almost_full(afull[3]));

  function automatic int get_cnt(int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string nm, input int got, input int req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int k, input logic [7:0] d);
    enq_valid[k] = 1'b1;
    enq_data[k]  = d;
    exp_q[k].push_back(d);
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 20) begin
      cyc();
      enq_valid[k] = 1'b0;
      deq_ready[k] = 1'b1;
      n++;
    end
    n_vec++;
    if (exp_q[k].size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout q%0d: got %0d entries left, required 0", k, exp_q[k].size());
    end
  endtask

  // Monitor: every dequeue fire must match the oldest expected element.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (deq_valid[k] && deq_ready[k]) begin
          n_vec++;
          if (exp_q[k].size() == 0) begin
            n_err++;
            $display("FAIL deq_unexpected q%0d: got %h, required no output", k, deq_data[k]);
          end else begin
            e = exp_q[k].pop_front();
            if (deq_data[k] !== e) begin
              n_err++;
              $display("FAIL deq_data q%0d: got %h, required %h", k, deq_data[k], e);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 4; k++) enq_data[k] = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", get_cnt(0), 0);
    chk("rst_deq_valid", int'(deq_valid[0]), 0);
    chk("rst_enq_ready", int'(enq_ready[0]), 1);
    chk("rst_afull", int'(afull[0]), 0);
    cyc();
    rst = 1'b0;

    // Fill A to full, almost_full from 2, no accept at full, FIFO order
    for (int i = 0; i < 3; i++) begin
      cyc();
      enq(0, 8'h0A + 8'(i));
      @(negedge clk);
      chk("fill_count", get_cnt(0), i);
      chk("fill_afull", int'(afull[0]), (i >= 2) ? 1 : 0);
      chk("fill_enq_ready", int'(enq_ready[0]), 1);
    end
    cyc();
    enq_valid[0] = 1'b1;
    enq_data[0]  = 8'hEE;
    deq_ready[0] = 1'b1;
    @(negedge clk);
    chk("full_count", get_cnt(0), 3);
    chk("full_afull", int'(afull[0]), 1);
    chk("full_enq_ready_nopipe", int'(enq_ready[0]), 0);
    drain(0);
    @(negedge clk);
    chk("drain_count", get_cnt(0), 0);

    // Wrap with occupancy held at 2
    cyc();
    deq_ready[0] = 1'b0;
    enq(0, 8'd1);
    cyc();
    enq(0, 8'd2);
    for (int v = 3; v <= 5; v++) begin
      cyc();
      enq(0, 8'(v));
      deq_ready[0] = 1'b1;
      @(negedge clk);
      chk("wrap_count", get_cnt(0), 2);
    end
    cyc();
    enq_valid[0] = 1'b0;
    @(negedge clk);
    chk("wrap_count_end", get_cnt(0), 2);
    drain(0);

    // Flush with count=2 while enqueue offered
    cyc();
    deq_ready[0] = 1'b0;
    enq(0, 8'h21);
    cyc();
    enq(0, 8'h22);
    cyc();
    flush[0]     = 1'b1;
    enq_valid[0] = 1'b1;
    enq_data[0]  = 8'h33;
    deq_ready[0] = 1'b1;
    exp_q[0].delete();
    @(negedge clk);
    chk("flush_enq_ready", int'(enq_ready[0]), 0);
    chk("flush_deq_valid", int'(deq_valid[0]), 0);
    cyc();
    flush[0]     = 1'b0;
    enq_valid[0] = 1'b0;
    @(negedge clk);
    chk("post_flush_count", get_cnt(0), 0);
    chk("post_flush_deq_valid", int'(deq_valid[0]), 0);
    cyc();
    enq(0, 8'h09);
    drain(0);

    // PIPE: full queue accepts while dequeuing
    cyc();
    deq_ready[1] = 1'b0;
    enq(1, 8'h61);
    cyc();
    enq(1, 8'h62);
    cyc();
    enq(1, 8'h63);
    cyc();
    enq(1, 8'h07);
    deq_ready[1] = 1'b1;
    @(negedge clk);
    chk("pipe_count_full", get_cnt(1), 3);
    chk("pipe_enq_ready", int'(enq_ready[1]), 1);
    cyc();
    enq_valid[1] = 1'b0;
    @(negedge clk);
    chk("pipe_count_held", get_cnt(1), 3);
    drain(1);

    // FALLTHROUGH: bypass when empty, storage path otherwise
    cyc();
    enq(2, 8'h55);
    deq_ready[2] = 1'b1;
    @(negedge clk);
    chk("ft_deq_valid", int'(deq_valid[2]), 1);
    chk("ft_count_same", get_cnt(2), 0);
    cyc();
    enq(2, 8'h56);
    deq_ready[2] = 1'b0;
    @(negedge clk);
    chk("ft_count_after_bypass", get_cnt(2), 0);
    cyc();
    enq_valid[2] = 1'b0;
    @(negedge clk);
    chk("ft_count_stored", get_cnt(2), 1);
    drain(2);

    // DEPTH=1 with PIPE: one per cycle
    for (int v = 0; v < 4; v++) begin
      cyc();
      enq(3, 8'hD0 + 8'(v));
      deq_ready[3] = 1'b1;
      @(negedge clk);
      chk("d1_enq_ready", int'(enq_ready[3]), 1);
      if (v > 0) chk("d1_count", get_cnt(3), 1);
    end
    cyc();
    enq_valid[3] = 1'b0;
    @(negedge clk);
    chk("d1_afull", int'(afull[3]), 1);
    drain(3);
    @(negedge clk);
    chk("d1_count_empty", get_cnt(3), 0);

    // Asynchronous reset between edges with A full
    cyc();
    deq_ready[0] = 1'b0;
    enq(0, 8'hB1);
    cyc();
    enq(0, 8'hB2);
    cyc();
    enq(0, 8'hB3);
    cyc();
    enq_valid[0] = 1'b0;
    @(negedge clk);
    chk("pre_rst_count", get_cnt(0), 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", get_cnt(0), 0);
    chk("async_rst_deq_valid", int'(deq_valid[0]), 0);
    chk("async_rst_enq_ready", int'(enq_ready[0]), 1);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    #1;
    rst = 1'b0;
    cyc();
    enq(0, 8'h44);
    drain(0);

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
